// File: rtl/mult_div.sv
// mult_div: multi-cycle multiply/divide unit with architectural HI/LO registers.
// Operands are latched at launch; the result commits on the edge that ends Busy.
module mult_div #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] D1,
   input  logic [31:0] D2,
   input  logic [2:0]  MDOp,
   input  logic        start,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

   // Counter is loaded with N-1 so Busy spans exactly N cycles
   localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES - 1);
   localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES - 1);

   logic [0:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_a;
   logic [31:0]   r_b;
   logic [2:0]    r_op;
   logic [31:0]   r_hi;
   logic [31:0]   r_lo;

   logic          w_launch;
   logic          w_is_mul;
   logic [63:0]   w_prod_s;
   logic [63:0]   w_prod_u;
   logic          w_signed;
   logic          w_a_neg;
   logic          w_b_neg;
   logic [31:0]   w_a_mag;
   logic [31:0]   w_b_mag;
   logic          w_dz;
   logic [31:0]   w_den;
   logic [31:0]   w_q_mag;
   logic [31:0]   w_r_mag;
   logic [31:0]   w_q;
   logic [31:0]   w_r;

   assign w_launch = start && (MDOp >= OP_MULT) && (MDOp <= OP_DIVU);
   assign w_is_mul = (MDOp == OP_MULT) || (MDOp == OP_MULTU);

   assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
   assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

   // Magnitude divide avoids the signed overflow of 0x80000000 / -1
   assign w_signed = (r_op == OP_DIV);
   assign w_a_neg  = w_signed & r_a[31];
   assign w_b_neg  = w_signed & r_b[31];
   assign w_a_mag  = w_a_neg ? (~r_a + 32'd1) : r_a;
   assign w_b_mag  = w_b_neg ? (~r_b + 32'd1) : r_b;
   assign w_dz     = (r_b == 32'd0);
   assign w_den    = w_dz ? 32'd1 : w_b_mag;
   assign w_q_mag  = w_a_mag / w_den;
   assign w_r_mag  = w_a_mag % w_den;
   assign w_q      = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
   assign w_r      = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_op    <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (MDOp == OP_MTHI) r_hi <= D1;
               if (MDOp == OP_MTLO) r_lo <= D1;
               if (w_launch) begin
                  r_a     <= D1;
                  r_b     <= D2;
                  r_op    <= MDOp;
                  r_cnt   <= w_is_mul ? MULT_LD : DIV_LD;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (r_cnt == '0) begin
                  r_state <= S_IDLE;
                  case (r_op)
                     OP_MULT:  {r_hi, r_lo} <= w_prod_s;
                     OP_MULTU: {r_hi, r_lo} <= w_prod_u;
                     OP_DIV, OP_DIVU: begin
                        if (!w_dz) begin
                           r_hi <= w_r;
                           r_lo <= w_q;
                        end
                     end
                     default: ;
                  endcase
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
         endcase
      end
   end

   assign Busy = (r_state == S_RUN);
   assign HI   = r_hi;
   assign LO   = r_lo;

endmodule

// File: tb/tb_mult_div.sv
// tb_mult_div: scoreboard bench for mult_div with a behavioural HI/LO model.
// Directed cases plus randomized ops; a negedge monitor checks each busy window.
module tb_mult_div;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] D1 = '0;
   logic [31:0] D2 = '0;
   logic [2:0]  MDOp = '0;
   logic        start = 1'b0;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;

   mult_div #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .D1(D1), .D2(D2),
      .MDOp(MDOp), .start(start), .Busy(Busy), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pre_hi;
      logic [31:0] pre_lo;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cycles;
   } exp_t;

   exp_t        sbq[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Architectural reference: plain 64-bit arithmetic
   task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo, output int cyc);
      int          ia;
      int          ib;
      longint      sa;
      longint      sb;
      longint      q;
      longint      r;
      logic [63:0] p;
      ia = a; ib = b; sa = ia; sb = ib;
      hi = m_hi; lo = m_lo; cyc = 0;
      case (op)
         3'd1: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; cyc = 5; end
         3'd2: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; cyc = 5; end
         3'd3: begin
            cyc = 10;
            if (b != 0) begin q = sa / sb; r = sa % sb; lo = 32'(q); hi = 32'(r); end
         end
         3'd4: begin
            cyc = 10;
            if (b != 0) begin lo = a / b; hi = a % b; end
         end
         default: ;
      endcase
   endtask

   task automatic wait_idle();
      int k = 0;
      while (Busy && k < 40) begin @(posedge clk); #1; k++; end
      if (Busy) begin
         n_cmp++; n_bad++;
         $display("FAIL busy_timeout: Busy still %b after %0d cycles", Busy, k);
      end
   endtask

   // Pushes the expectation, drives the start pulse, returns in busy cycle 1
   task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      e.pre_hi = m_hi; e.pre_lo = m_lo;
      model(op, a, b, e.hi, e.lo, e.cycles);
      m_hi = e.hi; m_lo = e.lo;
      sbq.push_back(e);
      D1 = a; D2 = b; MDOp = op; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; MDOp = 3'd0; D1 = $urandom; D2 = $urandom;
   endtask

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      launch(op, a, b);
      wait_idle();
   endtask

   task automatic mt_op(input logic [2:0] op, input logic [31:0] a, input logic st);
      D1 = a; D2 = $urandom; MDOp = op; start = st;
      if (op == 3'd5) m_hi = a;
      if (op == 3'd6) m_lo = a;
      @(posedge clk); #1;
      start = 1'b0; MDOp = 3'd0;
      chk("mt_busy", Busy, 0);
      chk("mt_hi", HI, m_hi);
      chk("mt_lo", LO, m_lo);
   endtask

   initial begin : monitor
      int   run;
      logic pb;
      exp_t e;
      run = 0; pb = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            run = 0; pb = 1'b0;
         end else if (Busy) begin
            run++; pb = 1'b1;
            if (sbq.size() > 0) begin
               chk("hold_hi", HI, sbq[0].pre_hi);
               chk("hold_lo", LO, sbq[0].pre_lo);
            end
         end else if (pb) begin
            pb = 1'b0;
            if (sbq.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_done: HI=%h LO=%h want no completion", HI, LO);
            end else begin
               e = sbq.pop_front();
               chk("busy_len", run, e.cycles);
               chk("res_hi", HI, e.hi);
               chk("res_lo", LO, e.lo);
            end
            run = 0;
         end
      end
   end

   logic [31:0] spec_vals [8] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000,
                                  32'h7FFFFFFF, 32'h2, 32'hFFFFFFF9, 32'h10};

   function automatic logic [31:0] pick();
      if ($urandom_range(0, 3) == 0) return spec_vals[$urandom_range(0, 7)];
      return $urandom;
   endfunction

   initial begin : stim
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      #12;
      chk("rst_busy", Busy, 0);
      chk("rst_hi", HI, 0);
      chk("rst_lo", LO, 0);
      @(posedge clk); #1;
      reset = 1'b0;

      run_op(3'd1, 32'hFFFFFFFE, 32'd3);
      chk("mult_hi", HI, 32'hFFFFFFFF);
      chk("mult_lo", LO, 32'hFFFFFFFA);
      run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
      chk("multu_hi", HI, 32'hFFFFFFFE);
      chk("multu_lo", LO, 32'h00000001);
      run_op(3'd3, 32'hFFFFFFF9, 32'd2);
      chk("div_lo", LO, 32'hFFFFFFFD);
      chk("div_hi", HI, 32'hFFFFFFFF);
      run_op(3'd4, 32'd7, 32'd2);
      chk("divu_lo", LO, 32'd3);
      chk("divu_hi", HI, 32'd1);
      run_op(3'd3, 32'h80000000, 32'hFFFFFFFF);
      chk("ovf_lo", LO, 32'h80000000);
      chk("ovf_hi", HI, 32'h00000000);

      mt_op(3'd5, 32'h12345678, 1'b0);
      mt_op(3'd6, 32'h9ABCDEF0, 1'b0);
      run_op(3'd3, 32'd1234, 32'd0);
      chk("dz_hi", HI, 32'h12345678);
      chk("dz_lo", LO, 32'h9ABCDEF0);

      // Ops arriving mid-run must be ignored
      launch(3'd1, 32'd1000, 32'hFFFFFFF0);
      @(posedge clk); #1;
      start = 1'b1; MDOp = 3'd3; D1 = $urandom; D2 = $urandom;
      @(posedge clk); #1;
      MDOp = 3'd6; D1 = $urandom; D2 = $urandom;
      @(posedge clk); #1;
      start = 1'b0; MDOp = 3'd0;
      wait_idle();

      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 7));
         a = pick();
         b = pick();
         if (op >= 3'd1 && op <= 3'd4) run_op(op, a, b);
         else mt_op(op, a, 1'($urandom_range(0, 1)));
      end

      run_op(3'd2, 32'hDEADBEEF, 32'h00C0FFEE);
      // Reset in busy cycle 4 of a divide
      launch(3'd3, 32'h7FFFFFFF, 32'd3);
      repeat (3) begin @(posedge clk); #1; end
      #2 reset = 1'b1;
      #1;
      chk("arst_busy", Busy, 0);
      chk("arst_hi", HI, 0);
      chk("arst_lo", LO, 0);
      sbq.delete();
      m_hi = '0; m_lo = '0;
      @(posedge clk); #1;
      reset = 1'b0;
      run_op(3'd1, 32'd6, 32'd7);
      repeat (12) begin @(posedge clk); #1; end
      chk("post_rst_hi", HI, m_hi);
      chk("post_rst_lo", LO, m_lo);

      @(negedge clk); #1;
      chk("sbq_empty", sbq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
